// File: rtl/bus_arb_pkg.sv
// Shared definitions for the per-bus round-robin arbiter: FSM encoding and default hold limit.
package bus_arb_pkg;

   typedef enum logic [1:0] {
      ARB_IDLE    = 2'b00,
      ARB_GRANT   = 2'b01,
      ARB_RELEASE = 2'b10
   } arbState_e;

   localparam int unsigned DEFAULT_MAX_HOLD = 64;

endpackage

// File: rtl/rr_priority_pick.sv
// Combinational round-robin search: first set bit of (req & ~mask) at or after startIdx, with wrap.
module rr_priority_pick #(
   parameter int unsigned N_CORES = 4,
   parameter int unsigned IDX_W   = $clog2(N_CORES)
) (
   input  logic [N_CORES-1:0] req,
   input  logic [N_CORES-1:0] mask,
   input  logic [IDX_W-1:0]   startIdx,
   output logic [IDX_W-1:0]   winner,
   output logic               valid
);

   logic [N_CORES-1:0] eligible;
   logic [IDX_W:0]     idx;

   assign eligible = req & ~mask;

   always_comb begin
      winner = '0;
      valid  = 1'b0;
      idx    = '0;
      for (int i = 0; i < int'(N_CORES); i++) begin
         // One extra bit holds startIdx + i before the wrap subtraction.
         idx = {1'b0, startIdx} + (IDX_W+1)'(i);
         if (idx >= (IDX_W+1)'(N_CORES)) begin
            idx = idx - (IDX_W+1)'(N_CORES);
         end
         if (!valid && eligible[idx[IDX_W-1:0]]) begin
            valid  = 1'b1;
            winner = idx[IDX_W-1:0];
         end
      end
   end

endmodule

// File: rtl/bus_rr_arbiter.sv
// Round-robin RQ/GRANT arbiter for one shared bus; new grants wait for the memory to drop Ready.
// Define BUS_ARB_TIMEOUT_EN to enable the hold-limit revoke with per-core lockout.
module bus_rr_arbiter
   import bus_arb_pkg::*;
#(
   parameter int unsigned N_CORES  = 4,
   parameter int unsigned IDX_W    = $clog2(N_CORES),
   parameter int unsigned MAX_HOLD = DEFAULT_MAX_HOLD
) (
   input  logic               clk,
   input  logic               reset,
   input  logic [N_CORES-1:0] bus_rq,
   input  logic               bus_mem_ready,
   output logic [N_CORES-1:0] bus_grant,
   output logic [IDX_W-1:0]   bus_owner,
   output logic               bus_busy,
   output logic               timeout_err
);

   localparam logic [IDX_W-1:0]   LastIdx = IDX_W'(N_CORES - 1);
   localparam logic [N_CORES-1:0] OneHot0 = N_CORES'(1);

   if (N_CORES < 2 || N_CORES > 16) begin : gBadCores
      $error("bus_rr_arbiter: N_CORES must be 2..16");
   end
   if (MAX_HOLD < 2 || MAX_HOLD > 65535) begin : gBadHold
      $error("bus_rr_arbiter: MAX_HOLD must be 2..65535");
   end

   arbState_e          stateQ;
   logic [N_CORES-1:0] grantQ;
   logic [IDX_W-1:0]   ownerQ;
   logic               busyQ;

   logic [N_CORES-1:0] pickMask;
   logic [IDX_W-1:0]   startIdx;
   logic [IDX_W-1:0]   winner;
   logic               pickValid;

`ifdef BUS_ARB_TIMEOUT_EN
   logic [15:0]        holdCntQ;
   logic [N_CORES-1:0] lockoutQ;
   logic               timeoutErrQ;

   assign pickMask    = lockoutQ;
   assign timeout_err = timeoutErrQ;
`else
   assign pickMask    = '0;
   assign timeout_err = 1'b0;
`endif

   // The core just served gets the lowest priority on the next search.
   assign startIdx = (ownerQ == LastIdx) ? '0 : ownerQ + 1'b1;

   rr_priority_pick #(
      .N_CORES (N_CORES),
      .IDX_W   (IDX_W)
   ) uPick (
      .req      (bus_rq),
      .mask     (pickMask),
      .startIdx (startIdx),
      .winner   (winner),
      .valid    (pickValid)
   );

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         stateQ      <= ARB_IDLE;
         grantQ      <= '0;
         ownerQ      <= LastIdx;
         busyQ       <= 1'b0;
`ifdef BUS_ARB_TIMEOUT_EN
         holdCntQ    <= '0;
         lockoutQ    <= '0;
         timeoutErrQ <= 1'b0;
`endif
      end else begin
`ifdef BUS_ARB_TIMEOUT_EN
         timeoutErrQ <= 1'b0;
         lockoutQ    <= lockoutQ & bus_rq;
`endif
         case (stateQ)
            ARB_IDLE: begin
               if (pickValid && !bus_mem_ready) begin
                  grantQ <= OneHot0 << winner;
                  ownerQ <= winner;
                  busyQ  <= 1'b1;
                  stateQ <= ARB_GRANT;
`ifdef BUS_ARB_TIMEOUT_EN
                  holdCntQ <= '0;
`endif
               end
            end
            ARB_GRANT: begin
               if (!bus_rq[ownerQ]) begin
                  grantQ <= '0;
                  stateQ <= ARB_RELEASE;
               end
`ifdef BUS_ARB_TIMEOUT_EN
               else if (holdCntQ == 16'(MAX_HOLD - 1)) begin
                  grantQ           <= '0;
                  stateQ           <= ARB_RELEASE;
                  timeoutErrQ      <= 1'b1;
                  lockoutQ[ownerQ] <= 1'b1;
               end else begin
                  holdCntQ <= holdCntQ + 16'd1;
               end
`endif
            end
            ARB_RELEASE: begin
               if (!bus_mem_ready) begin
                  stateQ <= ARB_IDLE;
                  busyQ  <= 1'b0;
               end
            end
            default: begin
               stateQ <= ARB_IDLE;
               grantQ <= '0;
               busyQ  <= 1'b0;
            end
         endcase
      end
   end

   assign bus_grant = grantQ;
   assign bus_owner = ownerQ;
   assign bus_busy  = busyQ;

endmodule

// File: tb/tb_bus_rr_arbiter.sv
// Directed bench for bus_rr_arbiter: vector table plus hand sequences for contention, reset, timeout.
module tb_bus_rr_arbiter;

   logic       clk;
   logic       reset;
   logic [3:0] bus_rq;
   logic       bus_mem_ready;
   logic [3:0] bus_grant;
   logic [1:0] bus_owner;
   logic       bus_busy;
   logic       timeout_err;

   int checks;
   int errors;

   bus_rr_arbiter #(
      .N_CORES  (4),
      .IDX_W    (2),
      .MAX_HOLD (8)
   ) dut (
      .clk           (clk),
      .reset         (reset),
      .bus_rq        (bus_rq),
      .bus_mem_ready (bus_mem_ready),
      .bus_grant     (bus_grant),
      .bus_owner     (bus_owner),
      .bus_busy      (bus_busy),
      .timeout_err   (timeout_err)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   typedef struct {
      logic [3:0] rq;
      logic       mr;
      logic [3:0] grant;
      logic [1:0] owner;
      logic       busy;
   } vec_t;

   vec_t vecs[21];

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0h, expected %0h", name, act, exp);
      end
   endtask

   task automatic doReset();
      @(negedge clk);
      reset = 1'b1;
      @(negedge clk);
      reset = 1'b0;
   endtask

   initial begin
      int n;
      logic [3:0] expGrant;
      checks        = 0;
      errors        = 0;
      reset         = 1'b1;
      bus_rq        = '0;
      bus_mem_ready = 1'b0;

      // {rq, mem_ready} applied before an edge -> {grant, owner, busy} after it
      vecs[0]  = '{4'b0001, 1'b0, 4'b0001, 2'd0, 1'b1};  // single request
      vecs[1]  = '{4'b0001, 1'b0, 4'b0001, 2'd0, 1'b1};
      vecs[2]  = '{4'b0000, 1'b0, 4'b0000, 2'd0, 1'b1};  // release
      vecs[3]  = '{4'b0000, 1'b0, 4'b0000, 2'd0, 1'b0};  // idle
      vecs[4]  = '{4'b0100, 1'b1, 4'b0000, 2'd0, 1'b0};  // memory busy blocks grant
      vecs[5]  = '{4'b0100, 1'b1, 4'b0000, 2'd0, 1'b0};
      vecs[6]  = '{4'b0100, 1'b0, 4'b0100, 2'd2, 1'b1};
      vecs[7]  = '{4'b0000, 1'b1, 4'b0000, 2'd2, 1'b1};  // release held by ready
      vecs[8]  = '{4'b0000, 1'b1, 4'b0000, 2'd2, 1'b1};
      vecs[9]  = '{4'b0000, 1'b1, 4'b0000, 2'd2, 1'b1};
      vecs[10] = '{4'b0000, 1'b0, 4'b0000, 2'd2, 1'b0};
      vecs[11] = '{4'b1111, 1'b0, 4'b1000, 2'd3, 1'b1};  // rr start after owner 2
      vecs[12] = '{4'b1111, 1'b0, 4'b1000, 2'd3, 1'b1};
      vecs[13] = '{4'b0111, 1'b0, 4'b0000, 2'd3, 1'b1};
      vecs[14] = '{4'b1111, 1'b0, 4'b0000, 2'd3, 1'b0};  // owner re-raises in release
      vecs[15] = '{4'b1111, 1'b0, 4'b0001, 2'd0, 1'b1};  // wraps to 0
      vecs[16] = '{4'b1110, 1'b0, 4'b0000, 2'd0, 1'b1};
      vecs[17] = '{4'b1111, 1'b0, 4'b0000, 2'd0, 1'b0};
      vecs[18] = '{4'b1111, 1'b0, 4'b0010, 2'd1, 1'b1};
      vecs[19] = '{4'b0000, 1'b0, 4'b0000, 2'd1, 1'b1};
      vecs[20] = '{4'b0000, 1'b0, 4'b0000, 2'd1, 1'b0};

      #2;
      check("async reset grant", 32'(bus_grant), 32'h0);
      check("async reset owner", 32'(bus_owner), 32'd3);
      check("async reset busy", 32'(bus_busy), 32'd0);
      check("async reset timeout", 32'(timeout_err), 32'd0);
      @(negedge clk);
      reset = 1'b0;
      tick();

      for (int i = 0; i < 21; i++) begin
         bus_rq        = vecs[i].rq;
         bus_mem_ready = vecs[i].mr;
         tick();
         check($sformatf("vec%0d grant", i), 32'(bus_grant), 32'(vecs[i].grant));
         check($sformatf("vec%0d owner", i), 32'(bus_owner), 32'(vecs[i].owner));
         check($sformatf("vec%0d busy", i), 32'(bus_busy), 32'(vecs[i].busy));
         check($sformatf("vec%0d timeout", i), 32'(timeout_err), 32'd0);
      end

      // Contention: all request, each owner holds 3 cycles then drops for one.
      doReset();
      bus_rq = 4'b1111;
      for (int k = 0; k < 5; k++) begin
         expGrant = 4'b0001 << (k % 4);
         n = 0;
         do begin
            tick();
            n++;
            check("contention onehot0", 32'($onehot0(bus_grant)), 32'd1);
         end while (bus_grant == 4'b0000 && n < 10);
         check($sformatf("contention grant %0d", k), 32'(bus_grant), 32'(expGrant));
         check($sformatf("contention gap %0d", k), 32'(n), (k == 0) ? 32'd1 : 32'd2);
         for (int c = 0; c < 2; c++) begin
            tick();
            check("contention hold", 32'(bus_grant), 32'(expGrant));
         end
         bus_rq = ~expGrant;
         tick();
         check("contention drop", 32'(bus_grant), 32'h0);
         bus_rq = 4'b1111;
      end

      // Mid-grant asynchronous reset.
      doReset();
      bus_rq = 4'b0100;
      tick();
      check("midreset pre grant", 32'(bus_grant), 32'b0100);
      #3;
      reset = 1'b1;
      #1;
      check("midreset grant", 32'(bus_grant), 32'h0);
      check("midreset owner", 32'(bus_owner), 32'd3);
      check("midreset busy", 32'(bus_busy), 32'd0);
      tick();
      reset  = 1'b0;
      bus_rq = 4'b0101;
      tick();
      check("postreset grant", 32'(bus_grant), 32'b0001);
      check("postreset owner", 32'(bus_owner), 32'd0);

      // Long hold by core 1 with core 3 also requesting.
      doReset();
      bus_rq = 4'b1010;
      tick();
      check("hold first grant", 32'(bus_grant), 32'b0010);
`ifdef BUS_ARB_TIMEOUT_EN
      for (int c = 0; c < 7; c++) begin
         tick();
         check("timeout hold", 32'(bus_grant), 32'b0010);
         check("timeout quiet", 32'(timeout_err), 32'd0);
      end
      tick();
      check("timeout revoke", 32'(bus_grant), 32'h0);
      check("timeout pulse", 32'(timeout_err), 32'd1);
      tick();
      check("timeout pulse end", 32'(timeout_err), 32'd0);
      tick();
      check("timeout next grant", 32'(bus_grant), 32'b1000);
      check("timeout next owner", 32'(bus_owner), 32'd3);
      bus_rq = 4'b0010;
      for (int c = 0; c < 4; c++) begin
         tick();
         check("lockout no grant", 32'(bus_grant), 32'h0);
      end
      bus_rq = 4'b0000;
      tick();
      bus_rq = 4'b0010;
      tick();
      check("lockout cleared grant", 32'(bus_grant), 32'b0010);
`else
      for (int c = 0; c < 100; c++) begin
         tick();
         check("nolimit hold", 32'(bus_grant), 32'b0010);
         check("nolimit timeout", 32'(timeout_err), 32'd0);
      end
`endif

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
